cordic_step_sequencer: RTL and testbench
========================================

CORDIC_STEP_SEQUENCER -- requirements
Module: cordic_step_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the tick divisor.
REQ-002 SHALL have parameter ITER, default 16, number of CORDIC iterations per operation (range 2..2^IDX_W).
REQ-003 SHALL have parameter IDX_W, default 4, width of the iteration index.
REQ-004 SHALL have port cin, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port div_val, input, DIV_W, step period minus one in cin cycles (0 = one step per cycle).
REQ-007 SHALL have port start, input, 1, level-sampled request to begin an operation.
REQ-008 SHALL have port abort, input, 1, terminates any operation in progress.
REQ-009 SHALL have port load, output, 1, one-cycle pulse telling the datapath to load its operands.
REQ-010 SHALL have port step_en, output, 1, one-cycle pulse: datapath performs iteration step_idx.
REQ-011 SHALL have port step_idx, output, IDX_W, iteration index, valid while step_en=1.
REQ-012 SHALL have port busy, output, 1, high from the load cycle through the done cycle inclusive.
REQ-013 SHALL have port done, output, 1, one-cycle pulse after the final step.

Function
REQ-014 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-015 IDLE: start=1 and abort=0 at edge T SHALL enter LOAD at T+1; abort=1 SHALL keep IDLE (abort wins over start).
REQ-016 LOAD SHALL last exactly one cycle with load=1, latch div_val into div_q, clear prescaler and index, then enter RUN.
REQ-017 RUN: prescaler SHALL count 0..div_q and wrap to 0; step_en=1 exactly in cycles where prescaler==div_q.
REQ-018 First step_en SHALL occur div_q cycles after RUN entry (cycle T+2+div_q); subsequent steps every div_q+1 cycles.
REQ-019 step_idx SHALL be 0 on the first step and increment by 1 after each step.
REQ-020 After the step with step_idx==ITER-1, state SHALL go to DONE next cycle; done=1 for that one cycle, then IDLE.
REQ-021 start while busy SHALL be ignored (no queueing); start held high in the DONE cycle SHALL start a new operation from IDLE on the following edge.
REQ-022 abort=1 in LOAD, RUN or DONE SHALL force IDLE on the next edge; step_en, load and done SHALL be 0 from that edge on, and done SHALL not pulse for the aborted operation.
REQ-023 abort and a final step in the same cycle: that step_en SHALL still be issued, but no done.
REQ-024 div_val changes after LOAD SHALL have no effect until the next operation.
REQ-025 div_val at its maximum (2^DIV_W-1) SHALL work without prescaler overflow; the prescaler SHALL be DIV_W bits.
REQ-026 load, step_en and done SHALL be mutually exclusive and all outputs registered.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, prescaler=0, index=0, div_q=0, load=0, step_en=0, step_idx=0, busy=0, done=0.
REQ-028 Reset mid-operation SHALL abandon the operation silently; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-029 State encoding and default ITER/IDX_W/DIV_W constants SHALL live in shared package cordic_seq_pkg.
REQ-030 The prescaler SHALL be sub-module tick_prescaler (inputs cin, rst_n, clr, en, period; output tick).

Verification
REQ-031 div_val=0, ITER=16, start pulse at T -> load at T+1, step_en T+2..T+17 with idx 0..15, done at T+18, busy low at T+19.
REQ-032 div_val=3 -> step_en at T+5, T+9, ..., T+65 (16 pulses), done at T+66.
REQ-033 div_val=3, abort at T+20 -> IDLE at T+21, no further step_en, no done; new start accepted afterwards.
REQ-034 start and abort both high in IDLE -> no load, busy stays 0.
REQ-035 rst_n low at T+10 of a div_val=0 run -> all outputs 0 immediately; after release, start -> full 16-step sequence.
REQ-036 div_val changed 3->7 at T+6 -> step spacing stays 4 cycles for the whole operation; start held high through busy -> no restart until after done.

Source files
------------

// File: rtl/cordic_seq_pkg.sv
// Shared definitions for the CORDIC step sequencer: FSM state encoding and
// default sizing constants.
package cordic_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // Default sizing: 16 iterations indexed by 4 bits, 16-bit tick divisor
  localparam int DEF_ITER  = 16;
  localparam int DEF_IDX_W = 4;
  localparam int DEF_DIV_W = 16;

endpackage

// File: rtl/cordic_step_sequencer_tick_prescaler.sv
// Step prescaler. clr/en describe the cycle that follows the coming edge:
// en=1 means the next cycle is a counting cycle, clr=1 means the next cycle
// restarts the count at 0. tick is registered and is high in exactly those
// counting cycles where the count equals period.
module tick_prescaler #(
  parameter int W = 16
) (
  input  logic         cin,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;
  logic         tick_reg;

  // Next count: restart on clear, otherwise count 0..period and wrap
  always_comb begin
    count_next = count_reg + 1'b1;
    if (clr || (count_reg == period)) begin
      count_next = '0;
    end
  end

  // Count register and look-ahead tick; idle cycles park the counter at 0
  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else if (en) begin
      count_reg <= count_next;
      tick_reg  <= (count_next == period);
    end else begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/cordic_step_sequencer.sv
// CORDIC step sequencer: issues a load pulse, ITER evenly spaced step pulses
// with an iteration index, and a done pulse. All outputs come straight from
// flops; their next values are derived from the next FSM state.
module cordic_step_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int ITER  = DEF_ITER,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             cin,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_val,
  input  logic             start,
  input  logic             abort,
  output logic             load,
  output logic             step_en,
  output logic [IDX_W-1:0] step_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITER - 1);

  seq_state_t       state_reg;
  seq_state_t       state_next;
  logic [DIV_W-1:0] div_q_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             load_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             tick;
  logic             presc_clr;
  logic             presc_en;

  // Next-state logic; abort beats start and ends any operation in flight
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (start && !abort) state_next = LOAD;
      LOAD: state_next = abort ? IDLE : RUN;
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tick && (idx_reg == LAST_IDX)) begin
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The first RUN cycle starts from count 0; counting only while staying in RUN
  assign presc_clr = (state_reg != RUN);
  assign presc_en  = (state_next == RUN);

  tick_prescaler #(
    .W(DIV_W)
  ) u_presc (
    .cin    (cin),
    .rst_n  (rst_n),
    .clr    (presc_clr),
    .en     (presc_en),
    .period (div_q_reg),
    .tick   (tick)
  );

  // State, divisor/index bookkeeping and registered status outputs
  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      div_q_reg <= '0;
      idx_reg   <= '0;
      load_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      load_reg  <= (state_next == LOAD);
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
      if (state_next == LOAD) begin
        // divisor is frozen here so later div_val changes wait for the next op
        div_q_reg <= div_val;
        idx_reg   <= '0;
      end else if (tick) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign load     = load_reg;
  assign step_en  = tick;
  assign step_idx = idx_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_cordic_step_sequencer.sv
// Directed bench for cordic_step_sequencer. Offsets below count clock edges
// after the edge T that first samples start=1 (offset k = cycle T+k).
module tb_cordic_step_sequencer;

  localparam int DIV_W = 6;
  localparam int ITER  = 16;
  localparam int IDX_W = 4;

  logic             cin = 1'b0;
  logic             rst_n = 1'b0;
  logic [DIV_W-1:0] div_val = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             load;
  logic             step_en;
  logic [IDX_W-1:0] step_idx;
  logic             busy;
  logic             done;

  cordic_step_sequencer #(
    .DIV_W(DIV_W),
    .ITER (ITER),
    .IDX_W(IDX_W)
  ) dut (
    .cin     (cin),
    .rst_n   (rst_n),
    .div_val (div_val),
    .start   (start),
    .abort   (abort),
    .load    (load),
    .step_en (step_en),
    .step_idx(step_idx),
    .busy    (busy),
    .done    (done)
  );

  always #5 cin = ~cin;

  int n_checks = 0;
  int n_fail = 0;

  int load_q[$];
  int step_q[$];
  int idx_q[$];
  int done_q[$];
  int busy_first;
  int busy_last;
  int excl_err;

  typedef struct {
    int div;
    int first;
    int last;
    int done_off;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Start an operation and record every output event for n_cyc cycles.
  task automatic run_seq(input int div, input int n_cyc, input bit hold,
                         input int abort_off, input int chg_off, input int chg_val);
    load_q.delete();
    step_q.delete();
    idx_q.delete();
    done_q.delete();
    busy_first = -1;
    busy_last  = -1;
    excl_err   = 0;
    @(negedge cin);
    div_val = div[DIV_W-1:0];
    start   = 1'b1;
    abort   = 1'b0;
    for (int k = 1; k <= n_cyc; k++) begin
      @(negedge cin);
      if (load) load_q.push_back(k);
      if (step_en) begin
        step_q.push_back(k);
        idx_q.push_back(int'(step_idx));
      end
      if (done) done_q.push_back(k);
      if (busy) begin
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (int'(load) + int'(step_en) + int'(done) > 1) excl_err++;
      start = hold;
      abort = (k == abort_off);
      if (k == chg_off) div_val = chg_val[DIV_W-1:0];
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  function automatic int bad_spacing(input int div);
    int n = 0;
    for (int i = 1; i < step_q.size(); i++)
      if (step_q[i] - step_q[i-1] != div + 1) n++;
    return n;
  endfunction

  function automatic int bad_idx();
    int n = 0;
    for (int i = 0; i < idx_q.size(); i++)
      if (idx_q[i] != i) n++;
    return n;
  endfunction

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int last_of(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  // Checks for one complete, undisturbed operation.
  task automatic check_full(input string tag, input int div, input int first,
                            input int last, input int done_off);
    check({tag, " load_count"}, load_q.size(), 1);
    check({tag, " load_off"}, first_of(load_q), 1);
    check({tag, " busy_first"}, busy_first, 1);
    check({tag, " step_count"}, step_q.size(), ITER);
    check({tag, " first_step"}, first_of(step_q), first);
    check({tag, " last_step"}, last_of(step_q), last);
    check({tag, " spacing_err"}, bad_spacing(div), 0);
    check({tag, " idx_err"}, bad_idx(), 0);
    check({tag, " done_count"}, done_q.size(), 1);
    check({tag, " done_off"}, first_of(done_q), done_off);
    check({tag, " busy_last"}, busy_last, done_off);
    check({tag, " excl_err"}, excl_err, 0);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000 && busy; k++) @(negedge cin);
    check("wait_idle busy", busy, 0);
  endtask

  initial begin
    bit saw;

    // div, first step, last step, done offset (ITER=16)
    vecs[0] = '{0, 2, 17, 18};
    vecs[1] = '{1, 3, 33, 34};
    vecs[2] = '{3, 5, 65, 66};
    vecs[3] = '{7, 9, 129, 130};
    vecs[4] = '{63, 65, 1025, 1026};

    // Reset state
    #1;
    check("rst load", load, 0);
    check("rst step_en", step_en, 0);
    check("rst step_idx", step_idx, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    @(negedge cin);
    rst_n = 1'b1;

    // Table-driven full operations
    for (int v = 0; v < 5; v++) begin
      run_seq(vecs[v].div, vecs[v].done_off + 3, 1'b0, -1, -1, 0);
      check_full($sformatf("div%0d", vecs[v].div), vecs[v].div,
                 vecs[v].first, vecs[v].last, vecs[v].done_off);
    end

    // Abort mid-run: abort high during cycle T+20
    run_seq(3, 80, 1'b0, 20, -1, 0);
    check("abort step_count", step_q.size(), 4);
    check("abort last_step", last_of(step_q), 17);
    check("abort done_count", done_q.size(), 0);
    check("abort busy_last", busy_last, 20);
    run_seq(0, 21, 1'b0, -1, -1, 0);
    check_full("after_abort", 0, 2, 17, 18);

    // start and abort together in IDLE
    @(negedge cin);
    start = 1'b1;
    abort = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge cin);
      saw = saw | load | busy;
    end
    check("start_abort load_or_busy", saw, 0);
    start = 1'b0;
    abort = 1'b0;

    // Abort during the final step cycle: step issued, no done
    run_seq(0, 22, 1'b0, 17, -1, 0);
    check("final_abort step_count", step_q.size(), ITER);
    check("final_abort last_step", last_of(step_q), 17);
    check("final_abort done_count", done_q.size(), 0);
    check("final_abort busy_last", busy_last, 17);

    // div_val 3->7 mid-op with start held: spacing stays 4, restart after done
    run_seq(3, 68, 1'b1, -1, 6, 7);
    check("chg load_count", load_q.size(), 2);
    check("chg reload_off", last_of(load_q), 68);
    check("chg step_count", step_q.size(), ITER);
    check("chg last_step", last_of(step_q), 65);
    check("chg spacing_err", bad_spacing(3), 0);
    check("chg done_off", first_of(done_q), 66);
    check("chg done_count", done_q.size(), 1);
    wait_idle();

    // Reset in the middle of a div_val=0 run
    @(negedge cin);
    div_val = '0;
    start = 1'b1;
    @(negedge cin);
    start = 1'b0;
    check("midrst load_off1", load, 1);
    repeat (9) @(negedge cin);
    check("midrst step_en_t10", step_en, 1);
    check("midrst step_idx_t10", step_idx, 8);
    #2 rst_n = 1'b0;
    #1;
    check("midrst load", load, 0);
    check("midrst step_en", step_en, 0);
    check("midrst step_idx", step_idx, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    @(negedge cin);
    rst_n = 1'b1;
    run_seq(0, 21, 1'b0, -1, -1, 0);
    check_full("after_rst", 0, 2, 17, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
